// File: rtl/input_debounce_buffer.sv
// ---------------------------------------------------------------------------
// input_debounce_buffer
//
// Purpose:
//   Synchronises and debounces a bank of slide switches and push buttons.
//   Debounced button presses are recorded as sticky event flags and as a
//   saturating 16-bit press counter. All state is exposed through a small
//   register window with a zero-latency read path.
//
// Parameters:
//   SW_W       switch input width (1..32)
//   BTN_W      button input width (1..16)
//   DB_CYCLES  consecutive disagreeing cycles needed before a debounced bit
//              follows its synchronised input (2..65535)
//
// Ports:
//   i_clk     rising-edge clock for all state
//   i_rst     synchronous active-high reset
//   i_io_sw   raw asynchronous switch levels
//   i_io_btn  raw asynchronous button levels, 1 = pressed
//   i_addr    register select: 0 switches, 1 buttons, 2 event flags,
//             3 press counter
//   i_rd_en   read strobe; reads of 2 and 3 with the strobe clear the register
//   o_rdata   combinational read data, unused upper bits read 0
// ---------------------------------------------------------------------------
module input_debounce_buffer #(
  parameter int SW_W      = 32,
  parameter int BTN_W     = 4,
  parameter int DB_CYCLES = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SW_W-1:0]  i_io_sw,
  input  logic [BTN_W-1:0] i_io_btn,
  input  logic [1:0]       i_addr,
  input  logic             i_rd_en,
  output logic [31:0]      o_rdata
);

  // Switches occupy the low bits of the combined vector, buttons the top.
  localparam int N      = SW_W + BTN_W;
  localparam int CNT_W  = $clog2(DB_CYCLES);
  localparam int RISE_W = $clog2(BTN_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // Number of buttons that produced a debounced rising edge this cycle.
  function automatic logic [RISE_W-1:0] count_rises(input logic [BTN_W-1:0] rises);
    logic [RISE_W-1:0] n;
    n = '0;
    for (int i = 0; i < BTN_W; i++) begin
      n = n + RISE_W'(rises[i]);
    end
    return n;
  endfunction

  // Press counter accumulation that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] acc,
                                            input logic [RISE_W-1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + 17'(inc);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [N-1:0]       raw;
  logic [N-1:0]       sync_p0;
  logic [N-1:0]       sync_p1;
  logic [N-1:0]       db_p2;
  logic [N-1:0]       db_next;
  logic [CNT_W-1:0]   cnt_p2   [N];
  logic [CNT_W-1:0]   cnt_next [N];
  logic [BTN_W-1:0]   btn_rise;
  logic [RISE_W-1:0]  n_rise;
  logic [BTN_W-1:0]   flags;
  logic [15:0]        press_cnt;
  logic               clr_flags;
  logic               clr_press;

  assign raw = {i_io_btn, i_io_sw};

  // ---- stage p0/p1: two-flop synchroniser on every raw input bit ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: per-bit debounce counters and debounced levels ----
  // A bit only flips once the synchronised value has disagreed with it on
  // DB_CYCLES consecutive edges; any agreeing edge restarts the count.
  always_comb begin
    db_next = db_p2;
    for (int i = 0; i < N; i++) begin
      cnt_next[i] = '0;
      if (sync_p1[i] != db_p2[i]) begin
        if (cnt_p2[i] == CNT_MAX) begin
          db_next[i] = sync_p1[i];
        end else begin
          cnt_next[i] = cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      db_p2 <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_p2[i] <= '0;
      end
    end else begin
      db_p2 <= db_next;
      for (int i = 0; i < N; i++) begin
        cnt_p2[i] <= cnt_next[i];
      end
    end
  end

  // Rises are taken from the next debounced value so the event registers on
  // the same edge as the debounced level change.
  assign btn_rise  = db_next[N-1:SW_W] & ~db_p2[N-1:SW_W];
  assign n_rise    = count_rises(btn_rise);
  assign clr_flags = i_rd_en && (i_addr == 2'd2);
  assign clr_press = i_rd_en && (i_addr == 2'd3);

  // ---- stage p3: event flags and press counter ----
  // On a clearing read the new rises are still applied, so a press landing on
  // the same edge as the read is never lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      flags     <= '0;
      press_cnt <= '0;
    end else begin
      flags     <= clr_flags ? btn_rise : (flags | btn_rise);
      press_cnt <= clr_press ? 16'(n_rise) : sat_add16(press_cnt, n_rise);
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      2'd0:    o_rdata = 32'(db_p2[SW_W-1:0]);
      2'd1:    o_rdata = 32'(db_p2[N-1:SW_W]);
      2'd2:    o_rdata = 32'(flags);
      2'd3:    o_rdata = {16'h0000, press_cnt};
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_input_debounce_buffer.sv
// ---------------------------------------------------------------------------
// tb_input_debounce_buffer
//
// Purpose:
//   Self-checking bench for input_debounce_buffer (SW_W=8, BTN_W=16,
//   DB_CYCLES=4; sixteen buttons let the press counter reach saturation in a
//   short run). A behavioural model tracks how long each synchronised bit has
//   disagreed with its debounced level and derives every register from that.
//   Directed sequences cover latency, glitches, clear-on-read, set-wins,
//   saturation and reset; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_input_debounce_buffer;

  localparam int SW    = 8;
  localparam int BTN   = 16;
  localparam int DB    = 4;
  localparam int NBITS = SW + BTN;

  logic           clk = 1'b0;
  logic           rst;
  logic [SW-1:0]  io_sw;
  logic [BTN-1:0] io_btn;
  logic [1:0]     addr;
  logic           rd_en;
  logic [31:0]    rdata;

  int n_checks = 0;
  int n_errors = 0;

  input_debounce_buffer #(
    .SW_W      (SW),
    .BTN_W     (BTN),
    .DB_CYCLES (DB)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_io_sw  (io_sw),
    .i_io_btn (io_btn),
    .i_addr   (addr),
    .i_rd_en  (rd_en),
    .o_rdata  (rdata)
  );

  always #10 clk = ~clk;

  // ---- reference model ----
  logic [NBITS-1:0] mq[$];        // raw samples still inside the synchroniser
  logic [NBITS-1:0] m_db;
  int               m_run [NBITS]; // consecutive edges synced != debounced
  logic [BTN-1:0]   m_flags;
  int               m_press;

  task automatic model_reset();
    mq.delete();
    mq.push_back('0);
    mq.push_back('0);
    m_db    = '0;
    for (int b = 0; b < NBITS; b++) m_run[b] = 0;
    m_flags = '0;
    m_press = 0;
  endtask

  task automatic model_step(input logic [NBITS-1:0] raw, input logic rst_v,
                            input logic [1:0] a, input logic rd);
    logic [NBITS-1:0] synced;
    logic [BTN-1:0]   old_btn;
    logic [BTN-1:0]   rise;
    int               n;
    if (rst_v) begin
      model_reset();
    end else begin
      synced = mq.pop_front();
      mq.push_back(raw);
      old_btn = m_db[NBITS-1:SW];
      for (int b = 0; b < NBITS; b++) begin
        if (synced[b] != m_db[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_db[b]  = synced[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      rise = m_db[NBITS-1:SW] & ~old_btn;
      n    = $countones(rise);
      if (rd && a == 2'd2) m_flags = rise;
      else                 m_flags = m_flags | rise;
      if (rd && a == 2'd3) m_press = n;
      else                 m_press = (m_press + n > 65535) ? 65535 : m_press + n;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_db[SW-1:0]};
      2'd1:    return {16'h0, m_db[NBITS-1:SW]};
      2'd2:    return {16'h0, m_flags};
      default: return {16'h0, m_press[15:0]};
    endcase
  endfunction

  // ---- checking ----
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare all four
  // registers against the model, apply the access, then advance the model.
  task automatic step(input logic [SW-1:0] sw, input logic [BTN-1:0] btn,
                      input logic [1:0] a, input logic rd, input logic rst_v);
    @(negedge clk);
    io_sw  = sw;
    io_btn = btn;
    rst    = rst_v;
    rd_en  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addr = 2'(k);
      #1;
      check_val($sformatf("model_addr%0d", k), rdata, model_read(2'(k)));
    end
    addr  = a;
    rd_en = rd;
    @(posedge clk);
    model_step({btn, sw}, rst_v, a, rd);
    #1;
  endtask

  // Side-effect-free read shortly after a rising edge, against a fixed value.
  task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string tag);
    rd_en = 1'b0;
    addr  = a;
    #1;
    check_val(tag, rdata, exp);
  endtask

  initial begin
    logic [SW-1:0]  sw_r;
    logic [BTN-1:0] btn_r;
    logic [BTN-1:0] bg;
    int             len;

    rst = 1'b1; io_sw = '0; io_btn = '0; addr = '0; rd_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) peek(2'(k), 32'h0, "reset_read");

    // Switch latency: visible only after the sixth edge.
    for (int k = 0; k < 6; k++) begin
      step(8'hA5, 16'h0, 2'd0, 1'b0, 1'b0);
      peek(2'd0, (k < 5) ? 32'h0 : 32'h0000_00A5, $sformatf("sw_latency_e%0d", k));
    end

    // Three-cycle glitch on btn[0] is filtered.
    repeat (3) step(8'hA5, 16'h0001, 2'd0, 1'b0, 1'b0);
    repeat (8) step(8'hA5, 16'h0000, 2'd0, 1'b0, 1'b0);
    peek(2'd1, 32'h0, "glitch_level");
    peek(2'd2, 32'h0, "glitch_flag");
    peek(2'd3, 32'h0, "glitch_press");

    // Held btn[2]: level, flag and one press; flag clears on strobed read.
    repeat (6) step(8'hA5, 16'h0004, 2'd0, 1'b0, 1'b0);
    peek(2'd1, 32'h4, "hold_level");
    peek(2'd2, 32'h4, "hold_flag");
    peek(2'd3, 32'h1, "hold_press");
    step(8'hA5, 16'h0004, 2'd2, 1'b1, 1'b0);
    peek(2'd2, 32'h0, "flag_clear");
    peek(2'd1, 32'h4, "level_after_clear");

    // Raise flag[3], then btn[1] rises on the edge of a flag-clearing read.
    repeat (6) step(8'hA5, 16'h000C, 2'd0, 1'b0, 1'b0);
    peek(2'd2, 32'h8, "flag3_set");
    repeat (5) step(8'hA5, 16'h000E, 2'd0, 1'b0, 1'b0);
    step(8'hA5, 16'h000E, 2'd2, 1'b1, 1'b0);
    peek(2'd2, 32'h2, "set_wins_clear");

    // Press counter: release all, clear, then pump towards saturation.
    repeat (8) step(8'hA5, 16'h0000, 2'd0, 1'b0, 1'b0);
    step(8'hA5, 16'h0000, 2'd3, 1'b1, 1'b0);
    peek(2'd3, 32'h0, "press_clear");
    for (int p = 0; p < 4095; p++) begin
      repeat (4) step(8'hA5, 16'hFFFF, 2'd0, 1'b0, 1'b0);
      repeat (4) step(8'hA5, 16'h0000, 2'd0, 1'b0, 1'b0);
    end
    peek(2'd3, 32'h0000_FFF0, "press_bulk");
    for (int p = 0; p < 3; p++) begin
      repeat (4) step(8'hA5, 16'h000F, 2'd0, 1'b0, 1'b0);
      repeat (4) step(8'hA5, 16'h0000, 2'd0, 1'b0, 1'b0);
    end
    repeat (4) step(8'hA5, 16'h0003, 2'd0, 1'b0, 1'b0);
    repeat (8) step(8'hA5, 16'h0000, 2'd0, 1'b0, 1'b0);
    peek(2'd3, 32'h0000_FFFE, "press_near_max");
    repeat (4) step(8'hA5, 16'h0003, 2'd0, 1'b0, 1'b0);
    repeat (8) step(8'hA5, 16'h0000, 2'd0, 1'b0, 1'b0);
    peek(2'd3, 32'h0000_FFFF, "press_saturated");
    repeat (4) step(8'hA5, 16'h0003, 2'd0, 1'b0, 1'b0);
    repeat (8) step(8'hA5, 16'h0000, 2'd0, 1'b0, 1'b0);
    peek(2'd3, 32'h0000_FFFF, "press_no_wrap");
    step(8'hA5, 16'h0000, 2'd3, 1'b1, 1'b0);
    peek(2'd3, 32'h0, "press_read_clear");

    // Reset in the middle of a btn[3] debounce, button held through release.
    repeat (4) step(8'hA5, 16'h0008, 2'd0, 1'b0, 1'b0);
    step(8'hA5, 16'h0008, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) peek(2'(k), 32'h0, "mid_reset_read");
    for (int k = 0; k < 6; k++) begin
      step(8'hA5, 16'h0008, 2'd0, 1'b0, 1'b0);
      peek(2'd2, (k < 5) ? 32'h0 : 32'h8, $sformatf("post_reset_flag_e%0d", k));
    end

    // Randomized segments with glitches, strobed reads and rare resets.
    for (int seg = 0; seg < 400; seg++) begin
      sw_r  = SW'($urandom);
      btn_r = BTN'($urandom);
      len   = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        bg = btn_r;
        if ($urandom_range(0, 7) == 0) bg = bg ^ BTN'(1 << $urandom_range(0, BTN - 1));
        step(sw_r, bg, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 99) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
